rr_free_list: RTL and testbench
===============================

RR_FREE_LIST -- requirements
Module: rr_free_list

Interface
REQ-001 Parameter INSTR_COUNT, default 2: rename/commit lanes per cycle.
REQ-002 Parameter P_REGISTERS, default 64: physical registers.
REQ-003 Parameter L_REGISTERS, default 32: logical registers. FL_DEPTH = P_REGISTERS-L_REGISTERS SHALL be a power of two. PREG_W = $clog2(P_REGISTERS). PTR_W = $clog2(FL_DEPTH)+1, where the MSB is the wrap bit.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 alloc_req  in  INSTR_COUNT  per-lane request for a destination physical register.
REQ-007 alloc_ready  out  1  all requested lanes granted this cycle.
REQ-008 alloc_p_reg  out  INSTR_COUNT x PREG_W  granted register per lane; only valid where alloc_req=1 and alloc_ready=1.
REQ-009 rel_en  in  INSTR_COUNT  per-lane release of a freed physical register at commit.
REQ-010 rel_p_reg  in  INSTR_COUNT x PREG_W  register released on each lane.
REQ-011 chk_head  out  PTR_W  current head pointer, captured by the RHT as the checkpoint.
REQ-012 rec_en  in  1  recovery request; restores the head pointer to rec_head.
REQ-013 rec_head  in  PTR_W  checkpointed head pointer to restore.
REQ-014 free_count  out  PTR_W  number of free entries currently held.
REQ-015 overflow_err  out  1  sticky flag: a release was attempted into a full list.

Function
REQ-016 The free list SHALL be a circular buffer of FL_DEPTH entries with head and tail pointers; free_count = tail-head, computed modulo 2^PTR_W.
REQ-017 Allocation is all-or-nothing: with n = popcount(alloc_req), alloc_ready=1 iff rec_en=0 and n <= avail, where avail is defined in REQ-026.
REQ-018 The k-th set lane, counting from lane 0, SHALL receive entry[head+k]. The grant is combinational in the same cycle (zero latency). Head SHALL advance by n at the clock edge only when alloc_ready=1.
REQ-019 When n=0, alloc_ready SHALL be 1 unless rec_en=1; head does not move.
REQ-020 Releases SHALL be written in lane order at tail, tail+1, ...; tail advances by popcount(rel_en). Releases are accepted irrespective of rec_en and alloc state.
REQ-021 If free_count + popcount(rel_en) would exceed FL_DEPTH, only the entries that fit SHALL be written, and overflow_err SHALL set and hold until reset.
REQ-022 When rec_en=1: head <= rec_head at the next edge, alloc_ready=0, and no grant occurs. A simultaneous release SHALL still update tail.
REQ-023 Pointer arithmetic SHALL wrap naturally at 2^PTR_W; entry index = pointer[PTR_W-2:0].
REQ-024 Simultaneous allocation and release in one cycle SHALL both take effect; the next free_count = free_count - n_granted + n_released.

Reset
REQ-025 While rst_n=0 at an edge: entry[i] <= L_REGISTERS+i for i in 0..FL_DEPTH-1, head <= 0, tail <= FL_DEPTH (wrap bit set), overflow_err <= 0. This gives free_count=FL_DEPTH, alloc_ready=1 for any request, and chk_head=0. Reset asserted mid-operation SHALL discard all in-flight state.

Configuration
REQ-026 Macro RR_FL_BYPASS_EN. Defined: avail = free_count + popcount(rel_en), and lanes beyond free_count are granted directly from rel_p_reg in release-lane order; bypassed registers are not written to the buffer, so tail advances only by the non-bypassed releases. Undefined: avail = free_count, and releases become allocatable from the next cycle.

Verification
REQ-027 Reset, then alloc_req=2'b11 -> alloc_p_reg={33,32}, alloc_ready=1; next cycle chk_head=2 and free_count=30.
REQ-028 32 allocations of 1 register, then alloc_req=2'b01 -> alloc_ready=0, head unchanged, free_count=0.
REQ-029 free_count=1, alloc_req=2'b11 -> alloc_ready=0 and nothing popped.
REQ-030 free_count=0, alloc_req=2'b01, rel_en=2'b01 with rel_p_reg=40. With bypass: grant 40, and free_count stays 0. Without bypass: alloc_ready=0, and next cycle free_count=1.
REQ-031 Record chk_head=4, allocate 6, assert rec_en with rec_head=4 and rel_en=2'b01 -> alloc_ready=0; next cycle head=4 and free_count increases by 7 relative to the pre-recovery value.
REQ-032 Full list (free_count=32), rel_en=2'b01 -> overflow_err=1 and stays 1; tail unchanged.

Source files
------------

// File: rtl/rr_free_list.sv
// Rename free list: circular buffer of free physical registers with checkpointable head.
// Optional macro RR_FL_BYPASS_EN lets same-cycle releases satisfy allocations directly.
module rr_free_list #(
    parameter int unsigned INSTR_COUNT = 2,
    parameter int unsigned P_REGISTERS = 64,
    parameter int unsigned L_REGISTERS = 32,
    localparam int unsigned FL_DEPTH   = P_REGISTERS - L_REGISTERS,
    localparam int unsigned PREG_W     = $clog2(P_REGISTERS),
    localparam int unsigned PTR_W      = $clog2(FL_DEPTH) + 1,
    localparam int unsigned IDX_W      = PTR_W - 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INSTR_COUNT-1:0]        alloc_req,
    output logic                          alloc_ready,
    output logic [INSTR_COUNT*PREG_W-1:0] alloc_p_reg,
    input  logic [INSTR_COUNT-1:0]        rel_en,
    input  logic [INSTR_COUNT*PREG_W-1:0] rel_p_reg,
    output logic [PTR_W-1:0]              chk_head,
    input  logic                          rec_en,
    input  logic [PTR_W-1:0]              rec_head,
    output logic [PTR_W-1:0]              free_count,
    output logic                          overflow_err
);

    logic [PREG_W-1:0] entry_q [FL_DEPTH];
    logic [PREG_W-1:0] entry_d [FL_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              overflow_q, overflow_d;

    logic [PTR_W-1:0]  free_cnt, n_req, n_rel, n_byp, n_rem, room, n_wr, k;
    logic [PTR_W:0]    avail;
    logic [PTR_W-1:0]  rel_rank [INSTR_COUNT];
`ifdef RR_FL_BYPASS_EN
    logic [PREG_W-1:0] rel_list [INSTR_COUNT];
`endif

    always_comb begin
        entry_d     = entry_q;
        head_d      = head_q;
        tail_d      = tail_q;
        overflow_d  = overflow_q;
        alloc_p_reg = '0;
        free_cnt    = tail_q - head_q;
        n_req       = '0;
        n_rel       = '0;
        k           = '0;
        n_byp       = '0;

        // rel_rank[i] is the position of lane i among the set release lanes
        for (int i = 0; i < INSTR_COUNT; i++) begin
            rel_rank[i] = n_rel;
            n_req       = n_req + PTR_W'(alloc_req[i]);
            n_rel       = n_rel + PTR_W'(rel_en[i]);
        end

`ifdef RR_FL_BYPASS_EN
        for (int j = 0; j < INSTR_COUNT; j++) begin
            rel_list[j] = '0;
            for (int i = 0; i < INSTR_COUNT; i++) begin
                if (rel_en[i] && (rel_rank[i] == PTR_W'(j)))
                    rel_list[j] = rel_p_reg[i*PREG_W +: PREG_W];
            end
        end
        avail = {1'b0, free_cnt} + {1'b0, n_rel};
`else
        avail = {1'b0, free_cnt};
`endif

        alloc_ready = !rec_en && ({1'b0, n_req} <= avail);

        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (alloc_req[i]) begin
                alloc_p_reg[i*PREG_W +: PREG_W] = entry_q[IDX_W'(head_q + k)];
`ifdef RR_FL_BYPASS_EN
                for (int j = 0; j < INSTR_COUNT; j++) begin
                    if ((k >= free_cnt) && ((k - free_cnt) == PTR_W'(j)))
                        alloc_p_reg[i*PREG_W +: PREG_W] = rel_list[j];
                end
`endif
                k = k + 1'b1;
            end
        end

`ifdef RR_FL_BYPASS_EN
        if (alloc_ready && (n_req > free_cnt))
            n_byp = n_req - free_cnt;
`endif

        // Releases past the bypassed ones are written at tail, clipped to the free room
        n_rem = n_rel - n_byp;
        room  = PTR_W'(FL_DEPTH) - free_cnt;
        n_wr  = (n_rem > room) ? room : n_rem;
        if (n_rem > room)
            overflow_d = 1'b1;

        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (rel_en[i] && (rel_rank[i] >= n_byp) && ((rel_rank[i] - n_byp) < n_wr))
                entry_d[IDX_W'(tail_q + rel_rank[i] - n_byp)] = rel_p_reg[i*PREG_W +: PREG_W];
        end
        tail_d = tail_q + n_wr;

        // Bypassed grants never consumed a buffer entry, so head skips them
        if (rec_en)
            head_d = rec_head;
        else if (alloc_ready)
            head_d = head_q + n_req - n_byp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FL_DEPTH); i++)
                entry_q[i] <= PREG_W'(L_REGISTERS + i);
            head_q     <= '0;
            tail_q     <= PTR_W'(FL_DEPTH);
            overflow_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    assign chk_head     = head_q;
    assign free_count   = free_cnt;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_rr_free_list.sv
// Bench for rr_free_list: directed vector tables plus random stimulus against a reference model.
module tb_rr_free_list;

    localparam int PW    = 6;
    localparam int DEPTH = 32;
    localparam int PMOD  = 64;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alloc_req;
    logic        alloc_ready;
    logic [11:0] alloc_p_reg;
    logic [1:0]  rel_en;
    logic [11:0] rel_p_reg;
    logic [5:0]  chk_head;
    logic        rec_en;
    logic [5:0]  rec_head;
    logic [5:0]  free_count;
    logic        overflow_err;

    rr_free_list dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_p_reg (alloc_p_reg),
        .rel_en      (rel_en),
        .rel_p_reg   (rel_p_reg),
        .chk_head    (chk_head),
        .rec_en      (rec_en),
        .rec_head    (rec_head),
        .free_count  (free_count),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: free registers live in ring positions [head, tail) of mem
    int mem [DEPTH];
    int mhead;
    int mtail;
    int movf;

    typedef struct {
        int rq; int rl; int r0; int r1; int rc; int rh;
        int rdy; int p0; int p1; int fc; int hd; int ovf;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int mfree();
        return (mtail - mhead + PMOD) % PMOD;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32 + i;
        mhead = 0;
        mtail = DEPTH;
        movf  = 0;
    endtask

    // Called at a negedge; returns at the next negedge with DUT outputs sampled in between
    task automatic apply(input int rq, input int rl, input int r0, input int r1,
                         input int rc, input int rh,
                         output int o_rdy, output int o_p0, output int o_p1);
        int nreq, free, avail, k, nbyp, rem, room, nwr, rdy;
        int gexp [2];
        int rlist [$];
        alloc_req = 2'(rq);
        rel_en    = 2'(rl);
        rel_p_reg = {6'(r1), 6'(r0)};
        rec_en    = 1'(rc);
        rec_head  = 6'(rh);

        free  = mfree();
        nreq  = ((rq & 1) != 0 ? 1 : 0) + ((rq & 2) != 0 ? 1 : 0);
        rlist = {};
        if ((rl & 1) != 0) rlist.push_back(r0);
        if ((rl & 2) != 0) rlist.push_back(r1);
        avail = free;
`ifdef RR_FL_BYPASS_EN
        avail = free + rlist.size();
`endif
        rdy = (rc == 0 && nreq <= avail) ? 1 : 0;
        k = 0;
        for (int i = 0; i < 2; i++) begin
            gexp[i] = -1;
            if (((rq >> i) & 1) != 0) begin
                if (k < free) gexp[i] = mem[(mhead + k) % DEPTH];
                else if (k - free < rlist.size()) gexp[i] = rlist[k - free];
                k++;
            end
        end

        #1;
        o_rdy = int'(alloc_ready);
        o_p0  = int'(alloc_p_reg[5:0]);
        o_p1  = int'(alloc_p_reg[11:6]);
        chk("model alloc_ready", o_rdy, rdy);
        if (rdy == 1) begin
            for (int i = 0; i < 2; i++)
                if (((rq >> i) & 1) != 0)
                    chk($sformatf("model grant lane%0d", i), int'(alloc_p_reg[i*PW +: PW]), gexp[i]);
        end

        @(posedge clk);
        nbyp = (rdy == 1 && nreq > free) ? nreq - free : 0;
        rem  = rlist.size() - nbyp;
        room = DEPTH - free;
        nwr  = (rem > room) ? room : rem;
        if (rem > room) movf = 1;
        for (int j = 0; j < nwr; j++) mem[(mtail + j) % DEPTH] = rlist[nbyp + j];
        mtail = (mtail + nwr) % PMOD;
        if (rc != 0) mhead = rh % PMOD;
        else if (rdy == 1) mhead = (mhead + nreq - nbyp) % PMOD;

        @(negedge clk);
        chk("model free_count", int'(free_count), mfree());
        chk("model chk_head", int'(chk_head), mhead);
        chk("model overflow_err", int'(overflow_err), movf);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        alloc_req = '0;
        rel_en    = '0;
        rel_p_reg = '0;
        rec_en    = 1'b0;
        rec_head  = '0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset free_count", int'(free_count), DEPTH);
        chk("reset chk_head", int'(chk_head), 0);
        chk("reset overflow_err", int'(overflow_err), 0);
    endtask

    function automatic vec_t mk(int rq, int rl, int r0, int r1, int rc, int rh,
                                int rdy, int p0, int p1, int fc, int hd, int ovf);
        vec_t v;
        v.rq = rq; v.rl = rl; v.r0 = r0; v.r1 = r1; v.rc = rc; v.rh = rh;
        v.rdy = rdy; v.p0 = p0; v.p1 = p1; v.fc = fc; v.hd = hd; v.ovf = ovf;
        return v;
    endfunction

    task automatic run_table(input string tag);
        int o_rdy, o_p0, o_p1;
        for (int n = 0; n < tv.size(); n++) begin
            apply(tv[n].rq, tv[n].rl, tv[n].r0, tv[n].r1, tv[n].rc, tv[n].rh, o_rdy, o_p0, o_p1);
            chk($sformatf("%s[%0d] ready", tag, n), o_rdy, tv[n].rdy);
            if (tv[n].p0 >= 0) chk($sformatf("%s[%0d] p0", tag, n), o_p0, tv[n].p0);
            if (tv[n].p1 >= 0) chk($sformatf("%s[%0d] p1", tag, n), o_p1, tv[n].p1);
            chk($sformatf("%s[%0d] free_count", tag, n), int'(free_count), tv[n].fc);
            chk($sformatf("%s[%0d] chk_head", tag, n), int'(chk_head), tv[n].hd);
            chk($sformatf("%s[%0d] overflow_err", tag, n), int'(overflow_err), tv[n].ovf);
        end
    endtask

    initial begin
        int o_rdy, o_p0, o_p1;
        rst_n     = 1'b0;
        alloc_req = '0;
        rel_en    = '0;
        rel_p_reg = '0;
        rec_en    = 1'b0;
        rec_head  = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Dual alloc, single-lane allocs, checkpoint/recovery with release, fill to full, overflow
        tv = {};
        //        rq rl r0  r1  rc rh rdy p0  p1 fc  hd ovf
        tv.push_back(mk(3, 0, 0,  0,  0, 0, 1, 32, 33, 30, 2, 0));
        tv.push_back(mk(1, 0, 0,  0,  0, 0, 1, 34, -1, 29, 3, 0));
        tv.push_back(mk(2, 0, 0,  0,  0, 0, 1, -1, 35, 28, 4, 0));
        tv.push_back(mk(3, 0, 0,  0,  0, 0, 1, 36, 37, 26, 6, 0));
        tv.push_back(mk(3, 0, 0,  0,  0, 0, 1, 38, 39, 24, 8, 0));
        tv.push_back(mk(3, 0, 0,  0,  0, 0, 1, 40, 41, 22, 10, 0));
        tv.push_back(mk(3, 1, 20, 0,  1, 4, 0, -1, -1, 29, 4, 0));
        tv.push_back(mk(0, 3, 21, 22, 0, 0, 1, -1, -1, 31, 4, 0));
        tv.push_back(mk(1, 1, 23, 0,  0, 0, 1, 36, -1, 31, 5, 0));
        tv.push_back(mk(0, 1, 36, 0,  0, 0, 1, -1, -1, 32, 5, 0));
        tv.push_back(mk(0, 1, 50, 0,  0, 0, 1, -1, -1, 32, 5, 1));
        tv.push_back(mk(0, 0, 0,  0,  0, 0, 1, -1, -1, 32, 5, 1));
        tv.push_back(mk(2, 2, 0,  51, 0, 0, 1, -1, 37, 31, 6, 1));
        run_table("seq_a");

        // Mid-operation reset, then drain one at a time to empty and the empty/one-left corners
        do_reset();
        tv = {};
        for (int i = 0; i < DEPTH; i++)
            tv.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32 + i, -1, 31 - i, i + 1, 0));
        tv.push_back(mk(1, 0, 0,  0, 0, 0, 0, -1, -1, 0, 32, 0));
        tv.push_back(mk(0, 1, 45, 0, 0, 0, 1, -1, -1, 1, 32, 0));
        tv.push_back(mk(3, 0, 0,  0, 0, 0, 0, -1, -1, 1, 32, 0));
        tv.push_back(mk(1, 0, 0,  0, 0, 0, 1, 45, -1, 0, 33, 0));
`ifdef RR_FL_BYPASS_EN
        tv.push_back(mk(1, 1, 40, 0, 0, 0, 1, 40, -1, 0, 33, 0));
`else
        tv.push_back(mk(1, 1, 40, 0, 0, 0, 0, -1, -1, 1, 33, 0));
`endif
        run_table("seq_b");

        // Random traffic; recovery targets keep the restored list within capacity
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int rq, rl, rc, rh, lim, nrl, d;
            if (c % 1000 == 700) do_reset();
            rq  = int'($urandom_range(0, 3));
            rl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            nrl = ((rl & 1) != 0 ? 1 : 0) + ((rl & 2) != 0 ? 1 : 0);
            rc  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            lim = DEPTH - mfree() - nrl;
            if (lim < 0) lim = 0;
            d   = int'($urandom_range(0, lim));
            rh  = (mhead - d + PMOD) % PMOD;
            apply(rq, rl, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), rc, rh,
                  o_rdy, o_p0, o_p1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
